// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits.
// Rejects false starts and flags every validated frame with its parity and framing status.
module uart_rx_cfg #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int UART_BPS  = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] po_data,
    output logic                 po_flag,
    output logic                 po_perr,
    output logic                 po_ferr
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int CNT_W        = (BAUD_CNT_MAX > 2) ? $clog2(BAUD_CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(BAUD_CNT_MAX / 2);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic                 rx_s1, rx_s2, rx_s3;
    logic [CNT_W-1:0]     baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 perr;
    logic                 ferr;

    logic start_edge;
    logic mid;
    logic wrap;
    logic par_x;
    logic perr_now;

    // rx_s2 is the synchronised line, rx_s3 its previous value for edge detection.
    assign start_edge = rx_s3 & ~rx_s2;
    assign mid        = (baud_cnt == CNT_MID);
    assign wrap       = (baud_cnt == CNT_LAST);
    assign par_x      = (^shift) ^ rx_s2;
    assign perr_now   = (PARITY == 1) ? ~par_x : par_x;

    // NOTE: every register here is state, so all of them use non-blocking assignments;
    // reset is synchronous and covers the shift register too, so outputs are defined from the first cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            po_data  <= '0;
            po_flag  <= 1'b0;
            po_perr  <= 1'b0;
            po_ferr  <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_s3   <= rx_s2;
            po_flag <= 1'b0;

            if (state != S_IDLE) begin
                baud_cnt <= wrap ? '0 : baud_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        state    <= S_START;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        perr     <= 1'b0;
                        ferr     <= 1'b0;
                    end
                end

                S_START: begin
                    // A line that is high again at mid-start was only a glitch.
                    if (mid && rx_s2) begin
                        state <= S_IDLE;
                    end else if (wrap) begin
                        state <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (mid) begin
                        shift   <= {rx_s2, shift[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (wrap && bit_cnt == LAST_DATA) begin
                        bit_cnt <= '0;
                        state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end

                S_PARITY: begin
                    if (mid) begin
                        perr <= perr_now;
                    end else if (wrap) begin
                        state <= S_STOP;
                    end
                end

                S_STOP: begin
                    // Leaving at the last mid-sample lets the next start edge arrive at any time.
                    if (mid) begin
                        if (bit_cnt == LAST_STOP) begin
                            state   <= S_IDLE;
                            po_flag <= 1'b1;
                            po_data <= shift;
                            po_perr <= perr;
                            po_ferr <= ferr | ~rx_s2;
                        end else begin
                            ferr    <= ferr | ~rx_s2;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: four configurations driven with directed and random frames,
// compared against expectations derived from the transmitted bit pattern.
module tb_uart_rx_cfg;

    typedef struct packed {
        logic [1:0] inst;
        logic       perr;
        logic       ferr;
        logic [8:0] data;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rx;

    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic [4:0] d3;
    logic [3:0] flag, pe, fe;

    int cfg_db  [4] = '{8, 8, 7, 5};
    int cfg_par [4] = '{0, 2, 0, 1};
    int cfg_sb  [4] = '{1, 1, 2, 2};
    int cfg_cpb [4] = '{10, 10, 10, 11};

    rec_t got_q[$];
    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .sys_clk(clk), .sys_rst(rst), .rx(rx[0]),
        .po_data(d0), .po_flag(flag[0]), .po_perr(pe[0]), .po_ferr(fe[0]));
    uart_rx_cfg #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .sys_clk(clk), .sys_rst(rst), .rx(rx[1]),
        .po_data(d1), .po_flag(flag[1]), .po_perr(pe[1]), .po_ferr(fe[1]));
    uart_rx_cfg #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u2 (
        .sys_clk(clk), .sys_rst(rst), .rx(rx[2]),
        .po_data(d2), .po_flag(flag[2]), .po_perr(pe[2]), .po_ferr(fe[2]));
    uart_rx_cfg #(.CLK_FREQ(1_100_000), .UART_BPS(100_000), .DATA_BITS(5), .PARITY(1), .STOP_BITS(2)) u3 (
        .sys_clk(clk), .sys_rst(rst), .rx(rx[3]),
        .po_data(d3), .po_flag(flag[3]), .po_perr(pe[3]), .po_ferr(fe[3]));

    // Every cycle with a flag high becomes one record, so a stretched pulse shows up as an extra frame.
    always @(negedge clk) begin
        if (flag[0]) got_q.push_back('{inst: 2'd0, perr: pe[0], ferr: fe[0], data: 9'(d0)});
        if (flag[1]) got_q.push_back('{inst: 2'd1, perr: pe[1], ferr: fe[1], data: 9'(d1)});
        if (flag[2]) got_q.push_back('{inst: 2'd2, perr: pe[2], ferr: fe[2], data: 9'(d2)});
        if (flag[3]) got_q.push_back('{inst: 2'd3, perr: pe[3], ferr: fe[3], data: 9'(d3)});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int inst, input logic [8:0] data, input logic perr, input logic ferr);
        exp_q.push_back('{inst: 2'(inst), perr: perr, ferr: ferr, data: data});
    endtask

    task automatic idle(input int inst, input int cycles);
        rx[inst] = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    // Builds the line image of one frame; rst_bit >= 0 pulses reset mid-way through that bit and expects no frame.
    task automatic send_frame(input int inst, input logic [8:0] data, input bit flip_par,
                              input logic [1:0] stops, input int rst_bit);
        logic [15:0] bits;
        logic [8:0]  d;
        logic        pbit;
        logic        ferr;
        int          n;
        d    = '0;
        bits = '0;
        ferr = 1'b0;
        n    = 1;
        for (int i = 0; i < cfg_db[inst]; i++) begin
            d[i]    = data[i];
            bits[n] = data[i];
            n++;
        end
        if (cfg_par[inst] != 0) begin
            pbit    = (cfg_par[inst] == 1) ? ~(^d) : (^d);
            bits[n] = pbit ^ flip_par;
            n++;
        end
        for (int s = 0; s < cfg_sb[inst]; s++) begin
            bits[n] = stops[s];
            if (!stops[s]) ferr = 1'b1;
            n++;
        end
        for (int b = 0; b < n; b++) begin
            rx[inst] = bits[b];
            for (int c = 0; c < cfg_cpb[inst]; c++) begin
                rst = (b == rst_bit) && (c == cfg_cpb[inst] / 2);
                @(negedge clk);
            end
        end
        rst      = 1'b0;
        rx[inst] = 1'b1;
        if (rst_bit < 0) push_exp(inst, d, flip_par && (cfg_par[inst] != 0), ferr);
    endtask

    task automatic drain(input string tag);
        rec_t g, e;
        repeat (40) @(negedge clk);
        check({tag, "_flag_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_inst"}, 32'(g.inst), 32'(e.inst));
            check({tag, "_data"}, 32'(g.data), 32'(e.data));
            check({tag, "_perr"}, 32'(g.perr), 32'(e.perr));
            check({tag, "_ferr"}, 32'(g.ferr), 32'(e.ferr));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [1:0] stops;
        int         gap;
        bit         flip;

        rx  = '1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", {8'(d0), 8'(d1), 8'(d2), 8'(d3)}, 32'h0);
        check("rst_flag", 32'(flag), 32'h0);
        check("rst_perr", 32'(pe), 32'h0);
        check("rst_ferr", 32'(fe), 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 back-to-back frames
        send_frame(0, 9'h00, 1'b0, 2'b11, -1);
        send_frame(0, 9'h01, 1'b0, 2'b11, -1);
        send_frame(0, 9'h0E, 1'b0, 2'b11, -1);
        send_frame(0, 9'h0C, 1'b0, 2'b11, -1);
        drain("b2b");

        // Even parity: correct, then inverted parity bit
        send_frame(1, 9'hA5, 1'b0, 2'b11, -1);
        send_frame(1, 9'hA5, 1'b1, 2'b11, -1);
        drain("even_par");

        // 7 data bits, 2 stops: second stop low, then a clean frame
        send_frame(2, 9'h55, 1'b0, 2'b01, -1);
        idle(2, 10);
        send_frame(2, 9'h2A, 1'b0, 2'b11, -1);
        drain("stop2");

        // Three-cycle glitch on an idle line
        rx[0] = 1'b0;
        repeat (3) @(negedge clk);
        idle(0, 30);
        drain("glitch");
        send_frame(0, 9'h3C, 1'b0, 2'b11, -1);
        drain("post_glitch");

        // Reset pulse during data bit 4 of 0xFF
        send_frame(0, 9'hFF, 1'b0, 2'b11, 5);
        check("midrst_data", 32'(d0), 32'h0);
        check("midrst_ferr", 32'(fe[0]), 32'h0);
        idle(0, 20);
        drain("midrst");
        send_frame(0, 9'h81, 1'b0, 2'b11, -1);
        drain("post_rst");

        // Break: 30 bit-times low gives exactly one framing-error frame
        rx[0] = 1'b0;
        repeat (30 * cfg_cpb[0]) @(negedge clk);
        push_exp(0, 9'h000, 1'b0, 1'b1);
        idle(0, 2 * cfg_cpb[0]);
        send_frame(0, 9'h12, 1'b0, 2'b11, -1);
        drain("break");

        // Random frames on every configuration
        for (int inst = 0; inst < 4; inst++) begin
            for (int k = 0; k < 15; k++) begin
                flip  = ($urandom_range(0, 3) == 0);
                stops = 2'b11;
                if ($urandom_range(0, 4) == 0) stops[0] = 1'b0;
                if ($urandom_range(0, 4) == 0) stops[1] = 1'b0;
                send_frame(inst, 9'($urandom), flip, stops, -1);
                gap = (stops != 2'b11) ? cfg_cpb[inst] : int'($urandom_range(0, cfg_cpb[inst]));
                idle(inst, gap);
            end
            drain("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
